// File: rtl/shift_req_pipe.sv
// Request FIFO plus registered result stage wrapped around the ALU's combinational barrel shifter.
// The FIFO head drives the shifter; its result is captured into the output stage.
module shift_req_pipe #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [4:0]               in_b,
    input  logic [1:0]               in_aluc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              sh_a,
    output logic [4:0]               sh_b,
    output logic [1:0]               sh_aluc,
    input  logic [31:0]              sh_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits on ready.

    logic [31:0]      r_mem_a    [DEPTH];
    logic [4:0]       r_mem_b    [DEPTH];
    logic [1:0]       r_mem_aluc [DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_out_valid;
    logic [31:0]      r_out_c;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_zero;
    logic [15:0]      r_done_cnt;

    logic             w_head_valid;
    logic             w_advance;
    logic             w_push;
    logic             w_pop;
    logic             w_out_fire;

    assign in_ready     = (r_count != FULL);
    assign w_head_valid = (r_count != '0);
    assign w_advance    = w_head_valid & (~r_out_valid | out_ready);
    // flush wins over both FIFO ports and over the output handshake count
    assign w_push       = in_valid & in_ready & ~flush;
    assign w_pop        = w_advance & ~flush;
    assign w_out_fire   = r_out_valid & out_ready & ~flush;

    assign sh_a    = w_head_valid ? r_mem_a[r_rd_ptr]    : '0;
    assign sh_b    = w_head_valid ? r_mem_b[r_rd_ptr]    : '0;
    assign sh_aluc = w_head_valid ? r_mem_aluc[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]    <= in_a;
            r_mem_b[r_wr_ptr]    <= in_b;
            r_mem_aluc[r_wr_ptr] <= in_aluc;
            r_mem_tag[r_wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_tag   <= '0;
            r_out_zero  <= 1'b1;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_out_c     <= sh_c;
            r_out_tag   <= r_mem_tag[r_rd_ptr];
            r_out_zero  <= (sh_c == 32'd0);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (w_out_fire) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_tag   = r_out_tag;
    assign out_zero  = r_out_zero;
    assign count     = r_count;
    assign done_cnt  = r_done_cnt;

endmodule
